// File: rtl/jk_response_checker.sv
// Response checker for a JK flip-flop: keeps a reference model of Q, compares the DUT
// outputs every enabled edge and flags, counts and latches mismatches.
module jk_response_checker #(
    parameter int CNT_W   = 8,
    parameter int ERR_W   = 4,
    parameter int MAX_ERR = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             J,
    input  logic             K,
    input  logic             Q,
    input  logic             nQ,
    output logic             synced,
    output logic             mismatch,
    output logic             err,
    output logic             fail,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] chk_count
);

    typedef enum logic [1:0] {SYNC, CHECK, FAIL} state_t;

    state_t             state, state_n;
    logic               model_q, model_n;
    logic               synced_n, mismatch_n, err_n, fail_n, bad;
    logic [ERR_W-1:0]   err_count_n, err_inc;
    logic [CNT_W-1:0]   chk_count_n;

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_chk(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    always_comb begin
        state_n     = state;
        model_n     = model_q;
        synced_n    = synced;
        mismatch_n  = mismatch;
        err_n       = err;
        fail_n      = fail;
        err_count_n = err_count;
        chk_count_n = chk_count;
        // Inputs reflect the DUT state after the previous edge, so compare before advancing.
        bad         = (Q != model_q) || (nQ == Q);
        err_inc     = sat_inc_err(err_count);

        if (en) begin
            case (state)
                SYNC: begin
                    // Hold/toggle from an unknown Q is undefined, so only J!=K can seed the model.
                    if (J != K) begin
                        model_n  = J;
                        synced_n = 1'b1;
                        state_n  = CHECK;
                    end
                end
                CHECK, FAIL: begin
                    mismatch_n  = bad;
                    chk_count_n = sat_inc_chk(chk_count);
                    if (bad) begin
                        err_n       = 1'b1;
                        err_count_n = err_inc;
                        // >= so a saturated counter still trips the threshold.
                        if (err_inc >= ERR_W'(MAX_ERR))
                            fail_n = 1'b1;
                    end
                    model_n = jk_next(model_q, J, K);
                    state_n = fail_n ? FAIL : CHECK;
                end
                default: state_n = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SYNC;
            model_q   <= 1'b0;
            synced    <= 1'b0;
            mismatch  <= 1'b0;
            err       <= 1'b0;
            fail      <= 1'b0;
            err_count <= '0;
            chk_count <= '0;
        end else begin
            state     <= state_n;
            model_q   <= model_n;
            synced    <= synced_n;
            mismatch  <= mismatch_n;
            err       <= err_n;
            fail      <= fail_n;
            err_count <= err_count_n;
            chk_count <= chk_count_n;
        end
    end

endmodule

// File: tb/tb_jk_response_checker.sv
// Bench for jk_response_checker: the bench plays the flip-flop under test (with fault
// injection), applies a vector table, hand sequences and random stimulus against a model.
module tb_jk_response_checker;

    logic       clk = 1'b0;
    logic       rst, en, J, K, Q, nQ;
    logic       synced, mismatch, err, fail;
    logic [3:0] err_count;
    logic [7:0] chk_count;

    jk_response_checker #(.CNT_W(8), .ERR_W(4), .MAX_ERR(3)) dut (
        .clk(clk), .rst(rst), .en(en), .J(J), .K(K), .Q(Q), .nQ(nQ),
        .synced(synced), .mismatch(mismatch), .err(err), .fail(fail),
        .err_count(err_count), .chk_count(chk_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Flip-flop under test, played by the bench; shares the checker enable as its clock enable.
    bit fq = 1'b0;

    // Reference model of the checker's observable behaviour.
    bit m_sync, m_q, m_mm, m_err, m_fail;
    int m_errc, m_chk;

    // Fault codes: 0 none, 1 Q inverted, 2 nQ equal to Q, 3 Q stuck at 0.
    typedef struct {
        bit r, e, j, k;
        int f;
        bit s, mm, er, fl;
        int ec, cc;
    } vec_t;

    vec_t tbl[$];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit j, input bit k, input int f);
        bit qv, nqv, bad;
        qv  = (f == 1) ? ~fq : (f == 3) ? 1'b0 : fq;
        nqv = (f == 2) ? qv : ~qv;
        rst = r; en = e; J = j; K = k; Q = qv; nQ = nqv;
        @(posedge clk);
        if (r) begin
            m_sync = 0; m_q = 0; m_mm = 0; m_err = 0; m_fail = 0; m_errc = 0; m_chk = 0;
        end else if (e) begin
            if (!m_sync) begin
                if (j != k) begin
                    m_q    = j;
                    m_sync = 1;
                end
            end else begin
                bad   = (qv != m_q) || (nqv == qv);
                m_chk = (m_chk >= 255) ? 255 : m_chk + 1;
                m_mm  = bad;
                if (bad) begin
                    m_err  = 1;
                    m_errc = (m_errc >= 15) ? 15 : m_errc + 1;
                    if (m_errc >= 3) m_fail = 1;
                end
                m_q = (j && k) ? ~m_q : (j != k) ? j : m_q;
            end
        end
        if (e) fq = (j && k) ? ~fq : (j != k) ? j : fq;
        #1;
    endtask

    task automatic check_model(input string tag);
        cmp({tag, " synced"},    32'(synced),    32'(m_sync));
        cmp({tag, " mismatch"},  32'(mismatch),  32'(m_mm));
        cmp({tag, " err"},       32'(err),       32'(m_err));
        cmp({tag, " fail"},      32'(fail),      32'(m_fail));
        cmp({tag, " err_count"}, 32'(err_count), 32'(m_errc));
        cmp({tag, " chk_count"}, 32'(chk_count), 32'(m_chk));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; J = 1'b0; K = 1'b0; Q = 1'b0; nQ = 1'b1;

        //        r  e  j  k  f   s mm er fl ec cc
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});  // reset
        tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0});  // sync on 10, no compare
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 2});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 3});
        tbl.push_back('{0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 4});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 5});
        tbl.push_back('{0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 6});
        tbl.push_back('{0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 7});  // golden run done, model Q=0
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8});  // Q=0 agrees with model
        tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8});  // enable gating
        tbl.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 8});
        tbl.push_back('{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 8});
        tbl.push_back('{0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 8});
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 9});  // resume, no false mismatch
        tbl.push_back('{0, 1, 1, 0, 1, 1, 1, 1, 0, 1, 10}); // Q forced wrong
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 11});
        tbl.push_back('{0, 1, 0, 0, 2, 1, 1, 1, 0, 2, 12}); // nQ forced equal to Q
        tbl.push_back('{0, 1, 0, 0, 0, 1, 0, 1, 0, 2, 13});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0});  // reset
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});  // J=K never syncs
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].r, tbl[i].e, tbl[i].j, tbl[i].k, tbl[i].f);
            cmp({tag, " synced"},    32'(synced),    32'(tbl[i].s));
            cmp({tag, " mismatch"},  32'(mismatch),  32'(tbl[i].mm));
            cmp({tag, " err"},       32'(err),       32'(tbl[i].er));
            cmp({tag, " fail"},      32'(fail),      32'(tbl[i].fl));
            cmp({tag, " err_count"}, 32'(err_count), 32'(tbl[i].ec));
            cmp({tag, " chk_count"}, 32'(chk_count), 32'(tbl[i].cc));
        end

        // Threshold and saturation: Q stuck at 0 with J/K=10 held.
        drive(1, 1, 1, 0, 3);
        drive(0, 1, 1, 0, 3);
        cmp("thr sync synced", 32'(synced), 32'd1);
        cmp("thr sync chk_count", 32'(chk_count), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 1, 0, 3);
            cmp($sformatf("thr%0d mismatch", i), 32'(mismatch), 32'd1);
            cmp($sformatf("thr%0d fail", i), 32'(fail), (i >= 3) ? 32'd1 : 32'd0);
            cmp($sformatf("thr%0d err_count", i), 32'(err_count), 32'((i > 15) ? 15 : i));
            cmp($sformatf("thr%0d chk_count", i), 32'(chk_count), 32'(i));
        end
        drive(1, 1, 1, 0, 3);
        cmp("rst in fail fail", 32'(fail), 32'd0);
        cmp("rst in fail synced", 32'(synced), 32'd0);
        cmp("rst in fail err", 32'(err), 32'd0);
        cmp("rst in fail err_count", 32'(err_count), 32'd0);
        cmp("rst in fail chk_count", 32'(chk_count), 32'd0);
        drive(0, 1, 1, 1, 0);
        cmp("after rst J=K synced", 32'(synced), 32'd0);

        // Random stimulus against the reference model.
        for (int i = 0; i < 600; i++) begin
            bit r, e, j, k;
            int f;
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 4) != 0);
            j = 1'($urandom_range(0, 1));
            k = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            drive(r, e, j, k, f);
            check_model($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
